// File: rtl/accum48_pkg.sv
// Shared constants and types for the 48-bit add/subtract accumulator.
package accum48_pkg;

    localparam int ACC_W = 48;

    // Encoding of the ADD_SUB control bit.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic [ACC_W-1:0] acc_word_t;

endpackage

// File: rtl/accum48_addsub.sv
// Registered 48-bit add/subtract-accumulate stage; P feeds back as the Z operand.
module accum48_addsub
    import accum48_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  acc_word_t operand,
    input  logic      add_sub,
    output acc_word_t p
);

    acc_word_t p_reg;
    acc_word_t p_next;

    // Plain modulo-2^48 arithmetic so the adder maps onto a DSP post-adder.
    always_comb begin
        p_next = p_reg;
        case (add_sub)
            OP_ADD:  p_next = p_reg + operand;
            default: p_next = p_reg - operand;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_reg <= '0;
        end else begin
            p_reg <= p_next;
        end
    end

    assign p = p_reg;

endmodule

// File: rtl/accum48.sv
// Accumulator top: optional input register stage feeding the add/subtract-accumulate stage.
module accum48
    import accum48_pkg::*;
#(
    parameter int A_W    = 24,
    parameter int C_W    = 24,
    parameter int IN_REG = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [A_W-1:0] A_IN,
    input  logic [C_W-1:0] C_IN,
    input  logic           ADD_SUB,
    output logic [ACC_W-1:0] ACCUM48_OUT
);

    acc_word_t operand_stage;
    logic      add_sub_stage;

    generate
        if (IN_REG == 1) begin : g_in_reg
            acc_word_t operand_reg;
            logic      add_sub_reg;

            // Mode bit travels with its operand so a mode change never skews by a cycle.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    operand_reg <= '0;
                    add_sub_reg <= OP_ADD;
                end else begin
                    operand_reg <= {A_IN, C_IN};
                    add_sub_reg <= ADD_SUB;
                end
            end

            assign operand_stage = operand_reg;
            assign add_sub_stage = add_sub_reg;
        end else begin : g_no_in_reg
            assign operand_stage = {A_IN, C_IN};
            assign add_sub_stage = ADD_SUB;
        end
    endgenerate

    accum48_addsub u_addsub (
        .CLK     (CLK),
        .RST     (RST),
        .operand (operand_stage),
        .add_sub (add_sub_stage),
        .p       (ACCUM48_OUT)
    );

endmodule

// File: tb/tb_accum48.sv
// Randomised and directed self-checking bench for accum48 against a queue-based reference model.
module tb_accum48;

    localparam int IN_REG = 1;

    typedef struct packed {
        logic [47:0] op;
        logic        sub;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] a_in = '0;
    logic [23:0] c_in = '0;
    logic        add_sub = 1'b0;
    logic [47:0] acc_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [47:0] exp_p;
    ent_t        pipe [$];

    accum48 #(.A_W(24), .C_W(24), .IN_REG(IN_REG)) dut (
        .CLK         (clk),
        .RST         (rst),
        .A_IN        (a_in),
        .C_IN        (c_in),
        .ADD_SUB     (add_sub),
        .ACCUM48_OUT (acc_out)
    );

    always #5 clk = ~clk;

    // Reference: operands wait IN_REG edges in a queue, then add or subtract into the sum.
    task automatic model_reset();
        ent_t z;
        z = '0;
        exp_p = '0;
        pipe.delete();
        for (int i = 0; i < IN_REG; i++) pipe.push_back(z);
    endtask

    task automatic model_edge();
        ent_t e;
        if (!rst) return;
        pipe.push_back({a_in, c_in, add_sub});
        if (pipe.size() > IN_REG) begin
            e = pipe.pop_front();
            exp_p = e.sub ? (exp_p - e.op) : (exp_p + e.op);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset for one cycle, releasing mid-cycle so the next edge is the first full one.
    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        tick();
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        model_reset();
        a_in = 24'($urandom);
        c_in = 24'($urandom);
        add_sub = 1'($urandom);
        #1;
        total_cnt++;
        if (acc_out !== 48'h0) $display("FAIL reset_immediate: got %h expected %h", acc_out, 48'h0);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            a_in = 24'($urandom);
            c_in = 24'($urandom);
            add_sub = 1'($urandom);
            total_cnt++;
            if (acc_out !== 48'h0) $display("FAIL reset_hold%0d: got %h expected %h", i, acc_out, 48'h0);
            else pass_cnt++;
        end
        #3;
        rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_add_then_sub();
        logic [47:0] exp_seq [5];
        exp_seq[0] = 48'h000000000000;
        exp_seq[1] = 48'h000200000202;
        exp_seq[2] = 48'h000400000404;
        exp_seq[3] = 48'h000600000606;
        exp_seq[4] = 48'h0005F60005F8;
        apply_reset();
        a_in = 24'd512; c_in = 24'd514; add_sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                a_in = 24'd10; c_in = 24'd14; add_sub = 1'b1;
            end
            tick();
            total_cnt++;
            if (acc_out !== exp_seq[i]) $display("FAIL add_sub_seq%0d: got %h expected %h", i, acc_out, exp_seq[i]);
            else pass_cnt++;
            $display("add_then_sub edge %0d out=%h", i, acc_out);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        a_in = 24'd0; c_in = 24'd1; add_sub = 1'b1;
        tick();
        total_cnt++;
        if (acc_out !== 48'h0) $display("FAIL wrap_latency: got %h expected %h", acc_out, 48'h0);
        else pass_cnt++;
        add_sub = 1'b0;
        tick();
        total_cnt++;
        if (acc_out !== 48'hFFFFFFFFFFFF) $display("FAIL wrap_down: got %h expected %h", acc_out, 48'hFFFFFFFFFFFF);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (acc_out !== 48'h0) $display("FAIL wrap_up: got %h expected %h", acc_out, 48'h0);
        else pass_cnt++;
        $display("test_wrap done out=%h", acc_out);
    endtask

    task automatic test_async_reset();
        logic [47:0] op;
        apply_reset();
        a_in = 24'($urandom_range(1, 24'hFFFFFF));
        c_in = 24'($urandom);
        add_sub = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (acc_out !== exp_p) $display("FAIL pre_reset_sum: got %h expected %h", acc_out, exp_p);
        else pass_cnt++;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        total_cnt++;
        if (acc_out !== 48'h0) $display("FAIL async_clear: got %h expected %h", acc_out, 48'h0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (acc_out !== 48'h0) $display("FAIL held_in_reset: got %h expected %h", acc_out, 48'h0);
        else pass_cnt++;
        #3;
        rst = 1'b1;
        a_in = 24'd3; c_in = 24'd7; add_sub = 1'b0;
        op = {24'd3, 24'd7};
        tick();
        total_cnt++;
        if (acc_out !== 48'h0) $display("FAIL resume_pending_discarded: got %h expected %h", acc_out, 48'h0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (acc_out !== op) $display("FAIL resume_first: got %h expected %h", acc_out, op);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (acc_out !== op * 2) $display("FAIL resume_second: got %h expected %h", acc_out, op * 2);
        else pass_cnt++;
        $display("test_async_reset done out=%h", acc_out);
    endtask

    task automatic test_mode_toggle();
        logic [47:0] op;
        logic [47:0] want;
        op = {24'd2020, 24'd2000};
        apply_reset();
        a_in = 24'd2020; c_in = 24'd2000;
        for (int i = 0; i < 6; i++) begin
            add_sub = 1'(i % 2);
            tick();
            want = (i % 2 == 1) ? op : 48'h0;
            total_cnt++;
            if (acc_out !== want) $display("FAIL toggle%0d: got %h expected %h", i, acc_out, want);
            else pass_cnt++;
            $display("toggle edge %0d add_sub=%0b out=%h", i, add_sub, acc_out);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            a_in = 24'($urandom);
            c_in = 24'($urandom);
            add_sub = 1'($urandom);
            tick();
            total_cnt++;
            if (acc_out !== exp_p) $display("FAIL random%0d: got %h expected %h", i, acc_out, exp_p);
            else pass_cnt++;
            $display("txn %0d a=%h c=%h sub=%0b out=%h", i, a_in, c_in, add_sub, acc_out);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_then_sub();
        test_wrap();
        test_async_reset();
        test_mode_toggle();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/accum48.md
ACCUM48 -- requirements
Module: accum48

Interface
REQ-001 Parameter A_W, 24, width of A_IN (upper operand field).
REQ-002 Parameter C_W, 24, width of C_IN (lower operand field); A_W + C_W SHALL equal 48.
REQ-003 Parameter IN_REG, 1, number of input register stages (0 or 1).
REQ-004 CLK  input  1  rising-edge system clock, sole clock domain.
REQ-005 RST  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 A_IN  input  24  upper half of the 48-bit operand, unsigned bit field.
REQ-007 C_IN  input  24  lower half of the 48-bit operand, unsigned bit field.
REQ-008 ADD_SUB  input  1  0 = accumulate by adding, 1 = accumulate by subtracting.
REQ-009 ACCUM48_OUT  output  48  accumulator register value, driven directly from a flop.

Function
REQ-010 Operand SHALL be the concatenation {A_IN, C_IN}, with A_IN in bits 47:24 and C_IN in bits 23:0; there is no multiply.
REQ-011 With IN_REG=1, A_IN, C_IN and ADD_SUB SHALL be captured together into one input register stage on every rising CLK edge.
REQ-012 Every rising CLK edge outside reset SHALL update the accumulator P: P <= P + OP when the registered ADD_SUB is 0, and P <= P - OP when it is 1.
REQ-013 Arithmetic SHALL be modulo 2^48 (wrap-around); no saturation, overflow flag or carry-out.
REQ-014 Latency SHALL be 2 edges from input change to first effect on ACCUM48_OUT when IN_REG=1, and 1 edge when IN_REG=0.
REQ-015 Accumulation SHALL be continuous, with no enable; a constant nonzero input adds or subtracts once per cycle.
REQ-016 ADD_SUB SHALL be sampled in the same register stage as its operand, so a mode change takes effect with exactly the operand presented alongside it.
REQ-017 No X/Z SHALL propagate from reset state; before the first valid input all registers hold 0.

Reset
REQ-018 RST=0 SHALL clear the input registers and P to 0 immediately (asynchronously), independent of CLK.
REQ-019 ACCUM48_OUT SHALL read 0 while RST=0.
REQ-020 Reset asserted mid-accumulation SHALL discard the running sum and any pending inputs.
REQ-021 Deassertion of RST SHALL be synchronised so that the first accumulation occurs on the first full CLK edge after release.
REQ-022 Inputs present in the cycle of release SHALL be captured normally on that edge.

Structure
REQ-023 A shared package accum48_pkg SHALL hold the ACC_W=48 constant and the ADD/SUB opcode encoding constants.
REQ-024 One sub-module, accum48_addsub, SHALL implement the registered 48-bit add/subtract-accumulate stage.
REQ-025 The top level SHALL contain only the optional input register stage and the instance of accum48_addsub.
REQ-026 Logic SHALL be inferable onto a single DSP48E-class slice: the concatenated operand feeds the adder, and P feeds back as the Z operand.

Verification
REQ-027 Hold RST=0 for 2 cycles with arbitrary inputs -> ACCUM48_OUT = 0x000000000000 throughout.
REQ-028 After reset, A_IN=512, C_IN=514, ADD_SUB=0 held for 3 accumulating edges -> outputs 0x000200000202, 0x000400000404, 0x000600000606.
REQ-029 From P=0x000600000606, apply A_IN=10, C_IN=14, ADD_SUB=1 for 1 accumulating edge -> 0x0005F60005F8.
REQ-030 From P=0, apply A_IN=0, C_IN=1, ADD_SUB=1 for 1 edge -> 0xFFFFFFFFFFFF; then ADD_SUB=0, same operand, 1 edge -> 0x000000000000 (wrap both directions).
REQ-031 Assert RST=0 between clock edges mid-accumulation -> output reads 0 before the next edge; accumulation resumes from 0 after release.
REQ-032 Toggle ADD_SUB with A_IN=2020, C_IN=2000 -> each edge's result reflects only the ADD_SUB registered with that operand (no one-cycle skew).
